des_round_controller: RTL and testbench

DES_ROUND_CONTROLLER -- requirements
Module: des_round_controller

---
 rtl/des_pkg.sv | 31 +++
 rtl/des_key_shift_rom.sv | 16 +
 rtl/des_round_controller.sv | 135 +++++++++++++
 tb/tb_des_round_controller.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared types and constants for the DES round controller.
// Holds the FSM state encoding and the per-round key-schedule rotate amounts.
package des_pkg;

  localparam int unsigned ROUNDS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_e;

  // Encrypt rotates C/D left; decrypt rotates right starting from the
  // already-rotated key, so its first round needs no shift.
  localparam logic [1:0] ENC_SHIFT [ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam logic [1:0] DEC_SHIFT [ROUNDS] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [1:0] shift_amount(input logic [3:0] idx, input logic dec);
    return dec ? DEC_SHIFT[idx] : ENC_SHIFT[idx];
  endfunction

endpackage

// File: rtl/des_key_shift_rom.sv
// Combinational key-schedule lookup: round index and mode to rotate amount/direction.
module des_key_shift_rom
  import des_pkg::*;
(
  input  logic [3:0] round_idx_i,
  input  logic       decrypt_i,
  output logic [1:0] key_shift_o,
  output logic       key_dir_o
);

  always_comb begin
    key_shift_o = shift_amount(round_idx_i, decrypt_i);
    key_dir_o   = decrypt_i;
  end

endmodule

// File: rtl/des_round_controller.sv
// Sequencing FSM for an iterative DES core: load, 16 rounds, final permutation, result handshake.
// Drives enables for the external permutation/round datapath only.
module des_round_controller
  import des_pkg::*;
#(
  parameter int unsigned FP_STAGES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_decrypt,
  output logic       in_ready,
  input  logic       abort,
  output logic       load_en,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic       key_dir,
  output logic [1:0] key_shift,
  output logic       last_round,
  output logic       fp_capture,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_decrypt,
  output logic       busy
);

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);
  localparam logic       FP_LAST  = 1'(FP_STAGES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mode_q, mode_d;
  logic       fp_cnt_q, fp_cnt_d;

  logic [1:0] rom_shift;
  logic       rom_dir;

  des_key_shift_rom u_rom (
    .round_idx_i (cnt_q),
    .decrypt_i   (mode_q),
    .key_shift_o (rom_shift),
    .key_dir_o   (rom_dir)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      fp_cnt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      fp_cnt_q <= fp_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    fp_cnt_d    = fp_cnt_q;
    in_ready    = 1'b0;
    load_en     = 1'b0;
    round_en    = 1'b0;
    fp_capture  = 1'b0;
    out_valid   = 1'b0;
    out_decrypt = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ST_LOAD;
          mode_d  = in_decrypt;
        end
      end
      ST_LOAD: begin
        load_en = 1'b1;
        cnt_d   = '0;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        round_en = 1'b1;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == LAST_IDX) begin
          state_d  = ST_FINAL;
          fp_cnt_d = 1'b0;
        end
      end
      ST_FINAL: begin
        if (fp_cnt_q == FP_LAST) begin
          fp_capture = 1'b1;
          fp_cnt_d   = 1'b0;
          state_d    = ST_DONE;
        end else begin
          fp_cnt_d = fp_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        out_valid   = 1'b1;
        out_decrypt = mode_q;
        in_ready    = out_ready;
        // Retire and accept in the same cycle so back-to-back blocks skip IDLE.
        if (out_ready) begin
          if (in_valid) begin
            state_d = ST_LOAD;
            mode_d  = in_decrypt;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      in_ready = 1'b0;
      state_d  = ST_IDLE;
      cnt_d    = '0;
      mode_d   = 1'b0;
      fp_cnt_d = 1'b0;
    end
  end

  always_comb begin
    round_idx  = round_en ? cnt_q : 4'd0;
    key_shift  = round_en ? rom_shift : 2'd0;
    key_dir    = round_en ? rom_dir : 1'b0;
    last_round = round_en && (cnt_q == LAST_IDX);
    busy       = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_des_round_controller.sv
// Directed self-checking bench for des_round_controller (FP_STAGES=1 and 2 instances).
module tb_des_round_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_decrypt, abort, out_ready;
  logic       in_ready, load_en, round_en, key_dir, last_round;
  logic       fp_capture, out_valid, out_decrypt, busy;
  logic [3:0] round_idx;
  logic [1:0] key_shift;

  logic       in_valid2, in_decrypt2;
  logic       in_ready2, load_en2, round_en2, key_dir2, last_round2;
  logic       fp_capture2, out_valid2, out_decrypt2, busy2;
  logic [3:0] round_idx2;
  logic [1:0] key_shift2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int unsigned enc_tbl [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int unsigned dec_tbl [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic [14:0] outs;
  assign outs = {in_ready, load_en, round_en, round_idx, key_dir, key_shift,
                 last_round, fp_capture, out_valid, out_decrypt, busy};

  des_round_controller #(.FP_STAGES(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_decrypt(in_decrypt),
    .in_ready(in_ready), .abort(abort), .load_en(load_en), .round_en(round_en),
    .round_idx(round_idx), .key_dir(key_dir), .key_shift(key_shift),
    .last_round(last_round), .fp_capture(fp_capture), .out_valid(out_valid),
    .out_ready(out_ready), .out_decrypt(out_decrypt), .busy(busy)
  );

  des_round_controller #(.FP_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_decrypt(in_decrypt2),
    .in_ready(in_ready2), .abort(1'b0), .load_en(load_en2), .round_en(round_en2),
    .round_idx(round_idx2), .key_dir(key_dir2), .key_shift(key_shift2),
    .last_round(last_round2), .fp_capture(fp_capture2), .out_valid(out_valid2),
    .out_ready(1'b1), .out_decrypt(out_decrypt2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller presents the request; the first edge here accepts it.
  task automatic run_block(input logic dec, input int unsigned hold,
                           input logic chain, input logic chain_dec);
    step();
    check("load_en", load_en, 1);
    check("load_busy", busy, 1);
    check("load_in_ready", in_ready, 0);
    check("load_round_en", round_en, 0);
    in_valid   = 1'b0;
    in_decrypt = ~dec;
    for (int k = 0; k < 16; k++) begin
      step();
      check("round_en", round_en, 1);
      check("round_idx", round_idx, k);
      check("key_dir", key_dir, dec);
      check("key_shift", key_shift, dec ? dec_tbl[k] : enc_tbl[k]);
      check("last_round", last_round, (k == 15));
      check("round_load_en", load_en, 0);
    end
    out_ready = (hold == 0);
    step();
    check("fp_capture", fp_capture, 1);
    check("fp_round_en", round_en, 0);
    check("fp_key_shift", key_shift, 0);
    check("fp_out_valid", out_valid, 0);
    step();
    for (int h = 0; h < int'(hold); h++) begin
      check("hold_out_valid", out_valid, 1);
      check("hold_out_decrypt", out_decrypt, dec);
      check("hold_in_ready", in_ready, 0);
      check("hold_round_en", round_en, 0);
      step();
    end
    out_ready  = 1'b1;
    in_valid   = chain;
    in_decrypt = chain_dec;
    #1;
    check("done_out_valid", out_valid, 1);
    check("done_out_decrypt", out_decrypt, dec);
    check("done_in_ready", in_ready, 1);
    check("done_fp_capture", fp_capture, 0);
  endtask

  logic bad;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_decrypt = 1'b0; abort = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_decrypt2 = 1'b0;
    step();
    step();
    check("reset_outs", outs, 15'h4000);
    rst = 1'b0;
    step();
    check("idle_outs", outs, 15'h4000);

    // FP_STAGES=2: fp_capture at cycle 19, out_valid at cycle 20
    in_valid2 = 1'b1; in_decrypt2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    check("fp2_load_en", load_en2, 1);
    for (int c = 2; c <= 20; c++) begin
      step();
      check("fp2_fp_capture", fp_capture2, (c == 19));
      check("fp2_out_valid", out_valid2, (c == 20));
    end
    check("fp2_out_decrypt", out_decrypt2, 1);
    step();
    check("fp2_idle", busy2, 0);

    // Encrypt, chained decrypt with 5-cycle backpressure, chained encrypt
    out_ready = 1'b1; in_valid = 1'b1; in_decrypt = 1'b0;
    run_block(1'b0, 0, 1'b1, 1'b1);
    run_block(1'b1, 5, 1'b1, 1'b0);
    run_block(1'b0, 0, 1'b0, 1'b0);
    step();
    check("back_to_idle", outs, 15'h4000);

    // Abort at round 7
    in_valid = 1'b1; in_decrypt = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    check("abort_round_idx", round_idx, 7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    #1;
    check("abort_outs", outs, 15'h4000);
    bad = 1'b0;
    repeat (25) begin
      step();
      if (fp_capture || out_valid || busy) bad = 1'b1;
    end
    check("abort_no_result", bad, 0);

    // Abort blocks acceptance in IDLE
    in_valid = 1'b1; in_decrypt = 1'b0; abort = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 0);
    step();
    check("abort_no_accept", busy, 0);
    abort = 1'b0;
    run_block(1'b0, 0, 1'b0, 1'b0);
    step();
    check("post_abort_idle", busy, 0);

    // Reset at round 12 with abort and in_valid asserted together
    in_valid = 1'b1; in_decrypt = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (13) step();
    check("rst_round_idx", round_idx, 12);
    rst = 1'b1; abort = 1'b1; in_valid = 1'b1;
    step();
    rst = 1'b0; abort = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_mid_outs", outs, 15'h4000);
    bad = 1'b0;
    repeat (25) begin
      step();
      if (out_valid || busy) bad = 1'b1;
    end
    check("rst_no_result", bad, 0);

    in_valid = 1'b1; in_decrypt = 1'b1;
    run_block(1'b1, 0, 1'b0, 1'b0);
    step();
    check("final_idle", outs, 15'h4000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
